// File: rtl/airlock_pressure_seq_pkg.sv
// Shared definitions for the airlock chamber sequencer: state encoding and fault codes.
package airlock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_HOLD  = 3'd2,
        ST_EVAC  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_DOOR    = 2'b01;
    localparam logic [1:0] FC_TIMEOUT = 2'b10;

    // True for the two states that drive a pump and run the phase timer.
    function automatic logic is_phase(input state_t st);
        return (st == ST_FILL) || (st == ST_EVAC);
    endfunction

endpackage

// File: rtl/airlock_pressure_seq_if.sv
// Door/sensor/request inputs and pump/status outputs of the airlock sequencer.
interface airlock_pressure_seq_if #(
    parameter int CNT_W = 8
);
    logic             begin_FandP;
    logic             begin_Evacuation;
    logic             InnerClosed;
    logic             OuterClosed;
    logic             Pressurized;
    logic             Evacuated;
    logic             fault_clr;
    logic             FandP;
    logic             Evacuate;
    logic             chamber_ready;
    logic             busy;
    logic             fault;
    logic [1:0]       fault_code;
    logic [CNT_W-1:0] phase_cnt;

    modport master (
        output begin_FandP, begin_Evacuation, InnerClosed, OuterClosed,
               Pressurized, Evacuated, fault_clr,
        input  FandP, Evacuate, chamber_ready, busy, fault, fault_code, phase_cnt
    );

    modport slave (
        input  begin_FandP, begin_Evacuation, InnerClosed, OuterClosed,
               Pressurized, Evacuated, fault_clr,
        output FandP, Evacuate, chamber_ready, busy, fault, fault_code, phase_cnt
    );
endinterface

// File: rtl/airlock_pressure_seq_phase_timer.sv
// Saturating phase timer with minimum-time and timeout compares against the registered count.
module airlock_phase_timer #(
    parameter int CNT_W          = 8,
    parameter int FILL_MIN       = 5,
    parameter int EVAC_MIN       = 7,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             clr,
    input  logic             en,
    input  logic             sel_evac,
    output logic [CNT_W-1:0] cnt,
    output logic             min_met,
    output logic             timeout
);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] FILL_LIM = CNT_W'(FILL_MIN - 1);
    localparam logic [CNT_W-1:0] EVAC_LIM = CNT_W'(EVAC_MIN - 1);
    localparam logic [CNT_W-1:0] TO_LIM   = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise increment and stick at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt     = cnt_q;
    assign min_met = sel_evac ? (cnt_q >= EVAC_LIM) : (cnt_q >= FILL_LIM);
    assign timeout = (cnt_q == TO_LIM);
endmodule

// File: rtl/airlock_pressure_seq.sv
// Airlock chamber sequencer: fill/pressurize, hold, evacuate with door interlock and latched fault.
module airlock_pressure_seq
    import airlock_pkg::*;
#(
    parameter int CNT_W          = 8,
    parameter int FILL_MIN       = 5,
    parameter int EVAC_MIN       = 7,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic                  Clock,
    input  logic                  Reset,
    airlock_pressure_seq_if.slave bus
);
    if ((TIMEOUT_CYCLES > (2**CNT_W) - 1) || (TIMEOUT_CYCLES <= FILL_MIN) ||
        (TIMEOUT_CYCLES <= EVAC_MIN)) begin : g_cfg_err
        $error("airlock_pressure_seq: TIMEOUT_CYCLES must fit CNT_W and exceed FILL_MIN/EVAC_MIN");
    end

    state_t           state_q, state_d;
    logic [1:0]       code_q, code_d;
    logic             fandp_q, fandp_d;
    logic             evac_q, evac_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             fault_q, fault_d;
    logic             doors_ok_s;
    logic             tmr_en_s;
    logic             min_met_s;
    logic             timeout_s;
    logic [CNT_W-1:0] cnt_s;

    assign doors_ok_s = bus.InnerClosed & bus.OuterClosed;

    // The timer only runs while staying in the same pump phase; any entry or exit restarts it at 0.
    assign tmr_en_s = is_phase(state_d) && (state_d == state_q);

    airlock_phase_timer #(
        .CNT_W          (CNT_W),
        .FILL_MIN       (FILL_MIN),
        .EVAC_MIN       (EVAC_MIN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .Clock    (Clock),
        .Reset    (Reset),
        .clr      (!tmr_en_s),
        .en       (tmr_en_s),
        .sel_evac (state_q == ST_EVAC),
        .cnt      (cnt_s),
        .min_met  (min_met_s),
        .timeout  (timeout_s)
    );

    // Next-state and fault-cause selection.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        case (state_q)
            ST_IDLE: begin
                if (doors_ok_s && bus.begin_FandP) begin
                    state_d = ST_FILL;
                end else if (doors_ok_s && bus.begin_Evacuation) begin
                    state_d = ST_EVAC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FILL, ST_EVAC: begin
                if (!doors_ok_s) begin
                    state_d = ST_FAULT;
                    code_d  = FC_DOOR;
                end else if (min_met_s &&
                             ((state_q == ST_FILL) ? bus.Pressurized : bus.Evacuated)) begin
                    state_d = (state_q == ST_FILL) ? ST_HOLD : ST_IDLE;
                end else if (timeout_s) begin
                    state_d = ST_FAULT;
                    code_d  = FC_TIMEOUT;
                end else begin
                    state_d = state_q;
                end
            end
            ST_HOLD: begin
                // Doors may open here for personnel transfer; only an evacuate request leaves.
                if (doors_ok_s && bus.begin_Evacuation) begin
                    state_d = ST_EVAC;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_FAULT: begin
                if (bus.fault_clr && doors_ok_s) begin
                    state_d = ST_IDLE;
                    code_d  = FC_NONE;
                end else begin
                    state_d = ST_FAULT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                code_d  = FC_NONE;
            end
        endcase
    end

    // Outputs decoded from the next state so they register alongside it.
    always_comb begin
        fandp_d = (state_d == ST_FILL);
        evac_d  = (state_d == ST_EVAC);
        ready_d = (state_d == ST_HOLD);
        busy_d  = is_phase(state_d);
        fault_d = (state_d == ST_FAULT);
    end

    // State and output registers; reset drops both pumps immediately.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            code_q  <= FC_NONE;
            fandp_q <= 1'b0;
            evac_q  <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            fandp_q <= fandp_d;
            evac_q  <= evac_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            fault_q <= fault_d;
        end
    end

    assign bus.FandP         = fandp_q;
    assign bus.Evacuate      = evac_q;
    assign bus.chamber_ready = ready_q;
    assign bus.busy          = busy_q;
    assign bus.fault         = fault_q;
    assign bus.fault_code    = code_q;
    assign bus.phase_cnt     = cnt_s;
endmodule

// File: tb/tb_airlock_pressure_seq.sv
// Directed self-checking bench for airlock_pressure_seq with default parameters.
module tb_airlock_pressure_seq;
    logic Clock;
    logic Reset;
    int   checks_cnt;
    int   errors_cnt;

    airlock_pressure_seq_if #(.CNT_W(8)) bus ();

    airlock_pressure_seq #(
        .CNT_W          (8),
        .FILL_MIN       (5),
        .EVAC_MIN       (7),
        .TIMEOUT_CYCLES (32)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_fandp"}, 32'(bus.FandP), 32'd0);
        check_eq({tag, "_evac"},  32'(bus.Evacuate), 32'd0);
        check_eq({tag, "_ready"}, 32'(bus.chamber_ready), 32'd0);
        check_eq({tag, "_busy"},  32'(bus.busy), 32'd0);
        check_eq({tag, "_fault"}, 32'(bus.fault), 32'd0);
        check_eq({tag, "_code"},  32'(bus.fault_code), 32'd0);
        check_eq({tag, "_cnt"},   32'(bus.phase_cnt), 32'd0);
    endtask

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        Reset = 1'b1;
        bus.begin_FandP      = 1'b0;
        bus.begin_Evacuation = 1'b0;
        bus.InnerClosed      = 1'b1;
        bus.OuterClosed      = 1'b1;
        bus.Pressurized      = 1'b0;
        bus.Evacuated        = 1'b0;
        bus.fault_clr        = 1'b0;
        repeat (2) @(posedge Clock);
        #1 Reset = 1'b0;
        check_idle("reset");

        // Fill: sensor asserted early is held off until the minimum, FandP lasts 5 cycles.
        bus.begin_FandP = 1'b1;
        step();
        bus.begin_FandP = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_eq("fill_fandp", 32'(bus.FandP), 32'd1);
            check_eq("fill_busy", 32'(bus.busy), 32'd1);
            check_eq("fill_cnt", 32'(bus.phase_cnt), 32'(i));
            check_eq("fill_ready", 32'(bus.chamber_ready), 32'd0);
            if (i == 2) bus.Pressurized = 1'b1;
            step();
        end
        bus.Pressurized = 1'b0;
        check_eq("hold_ready", 32'(bus.chamber_ready), 32'd1);
        check_eq("hold_fandp", 32'(bus.FandP), 32'd0);
        check_eq("hold_busy", 32'(bus.busy), 32'd0);
        check_eq("hold_cnt", 32'(bus.phase_cnt), 32'd0);

        // Door opening and fill request in HOLD are both harmless.
        bus.OuterClosed = 1'b0;
        bus.begin_FandP = 1'b1;
        step();
        step();
        check_eq("hold_door_ready", 32'(bus.chamber_ready), 32'd1);
        check_eq("hold_door_fault", 32'(bus.fault), 32'd0);
        check_eq("hold_req_fandp", 32'(bus.FandP), 32'd0);
        bus.OuterClosed = 1'b1;
        bus.begin_FandP = 1'b0;
        step();

        // Evacuate from HOLD, sensor on the 10th cycle.
        bus.begin_Evacuation = 1'b1;
        step();
        bus.begin_Evacuation = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check_eq("evac_on", 32'(bus.Evacuate), 32'd1);
            check_eq("evac_fandp", 32'(bus.FandP), 32'd0);
            check_eq("evac_cnt", 32'(bus.phase_cnt), 32'(i));
            if (i == 9) bus.Evacuated = 1'b1;
            step();
        end
        bus.Evacuated = 1'b0;
        check_idle("evac_done");

        // Door opens mid-fill at phase_cnt 3.
        bus.begin_FandP = 1'b1;
        step();
        bus.begin_FandP = 1'b0;
        step();
        step();
        step();
        check_eq("door_cnt3", 32'(bus.phase_cnt), 32'd3);
        bus.OuterClosed = 1'b0;
        step();
        check_eq("door_fault", 32'(bus.fault), 32'd1);
        check_eq("door_code", 32'(bus.fault_code), 32'd1);
        check_eq("door_fandp", 32'(bus.FandP), 32'd0);
        check_eq("door_cnt", 32'(bus.phase_cnt), 32'd0);
        bus.fault_clr = 1'b1;
        step();
        check_eq("clr_open_fault", 32'(bus.fault), 32'd1);
        check_eq("clr_open_code", 32'(bus.fault_code), 32'd1);
        bus.fault_clr   = 1'b0;
        bus.OuterClosed = 1'b1;
        bus.begin_FandP = 1'b1;
        step();
        check_eq("fault_req_fault", 32'(bus.fault), 32'd1);
        check_eq("fault_req_fandp", 32'(bus.FandP), 32'd0);
        bus.begin_FandP = 1'b0;
        bus.fault_clr   = 1'b1;
        step();
        bus.fault_clr = 1'b0;
        check_idle("door_clr");

        // No sensor: timeout exactly 32 cycles after FandP rose.
        bus.begin_FandP = 1'b1;
        step();
        bus.begin_FandP = 1'b0;
        for (int i = 0; i < 32; i++) begin
            check_eq("to_fandp", 32'(bus.FandP), 32'd1);
            check_eq("to_cnt", 32'(bus.phase_cnt), 32'(i));
            step();
        end
        check_eq("to_fault", 32'(bus.fault), 32'd1);
        check_eq("to_code", 32'(bus.fault_code), 32'd2);
        check_eq("to_fandp_off", 32'(bus.FandP), 32'd0);
        bus.fault_clr = 1'b1;
        step();
        bus.fault_clr = 1'b0;
        check_idle("to_clr");

        // Both requests together: fill wins.
        bus.begin_FandP      = 1'b1;
        bus.begin_Evacuation = 1'b1;
        step();
        bus.begin_FandP      = 1'b0;
        bus.begin_Evacuation = 1'b0;
        check_eq("both_fandp", 32'(bus.FandP), 32'd1);
        check_eq("both_evac", 32'(bus.Evacuate), 32'd0);
        bus.InnerClosed = 1'b0;
        step();
        check_eq("both_abort_code", 32'(bus.fault_code), 32'd1);
        bus.InnerClosed = 1'b1;
        bus.fault_clr   = 1'b1;
        step();
        bus.fault_clr = 1'b0;

        // Requests with a door open are dropped, not queued.
        bus.InnerClosed      = 1'b0;
        bus.begin_FandP      = 1'b1;
        bus.begin_Evacuation = 1'b1;
        step();
        step();
        check_idle("door_open_req");
        bus.begin_FandP      = 1'b0;
        bus.begin_Evacuation = 1'b0;
        bus.InnerClosed      = 1'b1;
        step();
        check_eq("no_queue_busy", 32'(bus.busy), 32'd0);

        // Asynchronous reset mid-evacuation.
        bus.begin_Evacuation = 1'b1;
        step();
        bus.begin_Evacuation = 1'b0;
        step();
        step();
        check_eq("pre_rst_evac", 32'(bus.Evacuate), 32'd1);
        #2 Reset = 1'b1;
        #1;
        check_eq("async_rst_evac", 32'(bus.Evacuate), 32'd0);
        check_eq("async_rst_busy", 32'(bus.busy), 32'd0);
        check_eq("async_rst_cnt", 32'(bus.phase_cnt), 32'd0);
        @(posedge Clock);
        #2 Reset = 1'b0;
        step();
        check_idle("post_rst");
        bus.begin_FandP = 1'b1;
        step();
        bus.begin_FandP = 1'b0;
        check_eq("post_rst_fill", 32'(bus.FandP), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end
endmodule
